// File: rtl/bht_update_ctrl_pkg.sv
// Shared types for the BHT update controller: counter encodings, FSM states,
// PC index slice bounds and the saturating-counter helper.
package bht_update_ctrl_pkg;

  typedef enum logic [1:0] {
    STRONG_NOT_TAKEN = 2'b00,
    WEAKLY_NOT_TAKEN = 2'b01,
    WEAKLY_TAKEN     = 2'b10,
    STRONG_TAKEN     = 2'b11
  } bht_cnt_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } upd_state_e;

  // Table index is taken from pc[IDX_HI:IDX_LO]; bits [1:0] are always zero.
  localparam int unsigned IDX_HI = 9;
  localparam int unsigned IDX_LO = 2;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    if (taken) begin
      if (cnt == STRONG_TAKEN) res = cnt;
      else                     res = cnt + 2'b01;
    end else begin
      if (cnt == STRONG_NOT_TAKEN) res = cnt;
      else                         res = cnt - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/bht_update_ctrl_fifo.sv
// bht_upd_fifo: dual-push / single-pop FIFO of {idx, taken} entries.
// Lane 0 lands in the tail slot ahead of lane 1; the caller guarantees room.
module bht_upd_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push0_i,
  input  logic [DATA_W-1:0]          push0_data_i,
  input  logic                       push1_i,
  input  logic [DATA_W-1:0]          push1_data_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          head_data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_next_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W-1:0]  tail_p1_s;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  push_n_s;
  logic              pop_s;

  // Pointer and occupancy next-state; flush returns everything to empty.
  always_comb begin
    push_n_s  = CNT_W'(push0_i) + CNT_W'(push1_i);
    pop_s     = pop_i && (count_q != '0);
    tail_p1_s = tail_q + PTR_W'(1);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(pop_s);
      tail_d  = tail_q + PTR_W'(push_n_s);
      count_d = count_q + push_n_s - CNT_W'(pop_s);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!rst && !flush_i) begin
      if (push0_i) mem_q[tail_q] <= push0_data_i;
      if (push1_i) mem_q[push0_i ? tail_p1_s : tail_q] <= push1_data_i;
    end
  end

  assign head_data_o  = mem_q[head_q];
  assign empty_o      = (count_q == '0);
  assign count_next_o = (rst) ? '0 : count_d;

endmodule

// File: rtl/bht_update_ctrl.sv
// bht_update_ctrl: init walk plus queued saturating-counter updates of the BHT.
// Optional `BHT_UPD_BYPASS_EN: lane 0 writes in its arrival cycle when the queue is empty.
module bht_update_ctrl
  import bht_update_ctrl_pkg::*;
#(
  parameter int unsigned IDX_W    = IDX_HI - IDX_LO + 1,
  parameter int unsigned Q_DEPTH  = 4,
  parameter logic [1:0]  INIT_CNT = WEAKLY_TAKEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  input  logic              commit0_valid,
  input  logic [31:0]       commit0_pc,
  input  logic              commit0_taken,
  input  logic              commit1_valid,
  input  logic [31:0]       commit1_pc,
  input  logic              commit1_taken,
  output logic              commit_ready,
  output logic [IDX_W-1:0]  bht_rd_idx,
  input  logic [1:0]        bht_rd_data,
  output logic              bht_wr_en,
  output logic [IDX_W-1:0]  bht_wr_idx,
  output logic [1:0]        bht_wr_data,
  output logic              init_busy
);

  localparam int unsigned CNT_W   = $clog2(Q_DEPTH) + 1;
  localparam int unsigned ENTRY_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] WALK_LAST = {IDX_W{1'b1}};

  upd_state_e         state_q;
  logic [IDX_W-1:0]   walk_q;
  logic               commit_ready_q;
  logic               init_busy_q;

  logic [IDX_W-1:0]   lane0_idx_s, lane1_idx_s, head_idx_s;
  logic               head_taken_s;
  logic [ENTRY_W-1:0] head_data_s;
  logic               fifo_empty_s;
  logic [CNT_W-1:0]   count_next_s;
  logic               live_s, accept_s, bypass_s;
  logic               push0_s, push1_s, pop_s;
  logic               unused_pc_bits;

  assign lane0_idx_s  = commit0_pc[IDX_W+IDX_LO-1:IDX_LO];
  assign lane1_idx_s  = commit1_pc[IDX_W+IDX_LO-1:IDX_LO];
  assign head_idx_s   = head_data_s[ENTRY_W-1:1];
  assign head_taken_s = head_data_s[0];
  assign unused_pc_bits = ^{commit0_pc[31:IDX_W+IDX_LO], commit0_pc[IDX_LO-1:0],
                            commit1_pc[31:IDX_W+IDX_LO], commit1_pc[IDX_LO-1:0]};

  // A cycle can only accept or drain work in RUN with no reset/clear pending.
  assign live_s   = !rst && !clear_req && (state_q == ST_RUN);
  assign accept_s = live_s && commit_ready_q;
`ifdef BHT_UPD_BYPASS_EN
  assign bypass_s = accept_s && commit0_valid && fifo_empty_s;
`else
  assign bypass_s = 1'b0;
`endif
  assign push0_s = accept_s && commit0_valid && !bypass_s;
  assign push1_s = accept_s && commit1_valid;
  assign pop_s   = live_s && !fifo_empty_s && !bypass_s;

  bht_upd_fifo #(
    .DEPTH  (Q_DEPTH),
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (clear_req),
    .push0_i      (push0_s),
    .push0_data_i ({lane0_idx_s, commit0_taken}),
    .push1_i      (push1_s),
    .push1_data_i ({lane1_idx_s, commit1_taken}),
    .pop_i        (pop_s),
    .head_data_o  (head_data_s),
    .empty_o      (fifo_empty_s),
    .count_next_o (count_next_s)
  );

  // Table port: init walk, bypassed lane 0, or queue head read-modify-write.
  always_comb begin
    bht_rd_idx  = head_idx_s;
    bht_wr_en   = 1'b0;
    bht_wr_idx  = head_idx_s;
    bht_wr_data = INIT_CNT;
    if (state_q == ST_INIT) begin
      bht_wr_en   = !rst && !clear_req;
      bht_wr_idx  = walk_q;
      bht_wr_data = INIT_CNT;
    end else if (bypass_s) begin
      bht_rd_idx  = lane0_idx_s;
      bht_wr_en   = 1'b1;
      bht_wr_idx  = lane0_idx_s;
      bht_wr_data = sat_update(bht_rd_data, commit0_taken);
    end else if (pop_s) begin
      bht_wr_en   = 1'b1;
      bht_wr_idx  = head_idx_s;
      bht_wr_data = sat_update(bht_rd_data, head_taken_s);
    end else begin
      bht_wr_en   = 1'b0;
    end
  end

  // Controller FSM with registered ready/busy flags.
  always_ff @(posedge clk) begin
    if (rst || clear_req) begin
      state_q        <= ST_INIT;
      walk_q         <= '0;
      commit_ready_q <= 1'b0;
      init_busy_q    <= 1'b1;
    end else begin
      case (state_q)
        ST_INIT: begin
          walk_q <= walk_q + IDX_W'(1);
          if (walk_q == WALK_LAST) begin
            state_q        <= ST_RUN;
            commit_ready_q <= 1'b1;
            init_busy_q    <= 1'b0;
          end else begin
            commit_ready_q <= 1'b0;
            init_busy_q    <= 1'b1;
          end
        end
        ST_RUN: begin
          commit_ready_q <= (count_next_s <= CNT_W'(Q_DEPTH - 2));
          init_busy_q    <= 1'b0;
        end
        default: begin
          state_q        <= ST_INIT;
          walk_q         <= '0;
          commit_ready_q <= 1'b0;
          init_busy_q    <= 1'b1;
        end
      endcase
    end
  end

  assign commit_ready = commit_ready_q;
  assign init_busy    = init_busy_q;

endmodule

// File: doc/bht_update_ctrl.md
Name: bht_update_ctrl

Overview:
Sequences all writes into the 256-entry 2-bit branch history table used by the IF-stage predictor.
- Accepts resolved branch outcomes from up to two ROB commit lanes per cycle and buffers them in a small FIFO.
- Performs the saturating-counter read-modify-write, one entry per cycle.
- Owns table initialisation: a 256-cycle walk after reset or on clear request.
- Sits between the ROB commit stage and the predictor's table storage.

Parameters:
IDX_W, 8, table index width; entries = 2**IDX_W
Q_DEPTH, 4, update FIFO depth (power of two, >= 2)
INIT_CNT, 2'b10, counter value written during init walk (WEAKLY_TAKEN)

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
clear_req  in  1  one-cycle pulse; discard queue and re-initialise table
commit0_valid  in  1  lane 0 branch outcome valid
commit0_pc  in  32  lane 0 branch pc
commit0_taken  in  1  lane 0 actual direction
commit1_valid  in  1  lane 1 outcome valid (older-than-lane-1 ordering: lane 0 first)
commit1_pc  in  32  lane 1 branch pc
commit1_taken  in  1  lane 1 actual direction
commit_ready  out  1  high when FIFO can accept two entries this cycle
bht_rd_idx  out  IDX_W  combinational read address into table
bht_rd_data  in  2  combinational counter at bht_rd_idx
bht_wr_en  out  1  table write strobe
bht_wr_idx  out  IDX_W  write address
bht_wr_data  out  2  write data
init_busy  out  1  high during init walk; predictor must treat prediction as not-taken

Behaviour:
- Index is pc[IDX_W+1:2].
- States: INIT, RUN.
- Reset values: state=INIT, walk counter=0, FIFO empty (head=tail=count=0), commit_ready=0, bht_wr_en=0, init_busy=1.
- INIT:
  - Each cycle: bht_wr_en=1, wr_idx=walk counter, wr_data=INIT_CNT; walk counter increments.
  - After writing index 2**IDX_W-1 → RUN next cycle. Total 256 write cycles.
  - commit_ready=0; commit inputs ignored.
- RUN:
  - commit_ready = (free slots >= 2), registered from count.
  - Push when commit_ready && valid: lane 0 pushed before lane 1; either lane may be valid alone.
  - Pushes with commit_ready=0 are dropped; the ROB must hold.
  - Drain: if FIFO non-empty, head entry drives bht_rd_idx.
  - Same cycle: bht_wr_en=1, wr_idx=head idx, wr_data=sat(bht_rd_data ± 1). +1 if taken, saturating at 2'b11; -1 if not taken, saturating at 2'b00. Head pops.
  - Back-to-back updates to the same index are correct, since the read sees the previous edge's write.
  - Simultaneous push and pop in one cycle are legal; count updates by pushes minus pop.
  - bht_wr_en=0 when FIFO is empty.
  - Pointers wrap modulo Q_DEPTH.
- clear_req (any state):
  - Next state INIT with walk counter=0; FIFO flushed.
  - Same-cycle pushes and the same-cycle drain write are suppressed.
  - clear_req during INIT restarts the walk from 0.
- rst has priority over clear_req.
- Latency: commit at edge N → table write at edge N+1 when the queue was empty.

Optional Feature:
- Macro: BHT_UPD_BYPASS_EN.
- When defined: in RUN with FIFO empty and commit_ready, lane 0 bypasses the FIFO and is written in its arrival cycle (bht_rd_idx/bht_wr_* driven from lane 0 directly, latency 0). Lane 1, if valid, is enqueued.
- When undefined: all updates pass through the FIFO as above.
- commit_ready rule is unchanged in both builds.

Decomposition:
- Shared package/defines:
  - Counter encodings STRONG_NOT_TAKEN=00, WEAKLY_NOT_TAKEN=01, WEAKLY_TAKEN=10, STRONG_TAKEN=11.
  - Index slice macro 9:2.
  - State encodings INIT/RUN.
- One natural sub-module: bht_upd_fifo, a dual-push single-pop FIFO storing {idx, taken}.

Test Plan:
- Reset 1 cycle → init_busy=1 for 256 cycles, writes idx 0..255 with 2'b10, then init_busy=0 and commit_ready=1.
- After init: lane0 pc=0x1000, taken=1, with table[0x00]=10 → one cycle later wr_idx=0x00, wr_data=11. Repeat → wr_data stays 11 (saturation).
- Lane0 pc=0x1004 not-taken and lane1 pc=0x1004 not-taken in the same cycle, starting from 10 → writes 01 then 00 on consecutive cycles; third not-taken → 00.
- Push two entries per cycle for 3 cycles → commit_ready drops when count>2; dropped pushes never produce writes; every accepted entry is written in FIFO order.
- clear_req with 3 entries queued → no queued writes occur; a new 256-cycle walk starts next cycle. rst mid-walk at index 100 → walk restarts at 0.
- BHT_UPD_BYPASS_EN defined, queue empty: lane0 pc=0x2008 taken → bht_wr_en in the same cycle, idx 0x02. Undefined build → write one cycle later.
